// File: rtl/bingo_board_tracker.sv
// N x N bingo board held in registers. Each accepted move triggers a
// 2N+2 cycle scan (rows, columns, main diagonal, anti-diagonal) that refreshes counts and winner.
module bingo_board_tracker #(
    parameter int N  = 3,
    parameter int CW = $clog2(N),
    parameter int LW = $clog2(N+1)
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CLEAR,
    input  logic          MOVE_VALID,
    output logic          MOVE_READY,
    input  logic [CW-1:0] MOVE_ROW,
    input  logic [CW-1:0] MOVE_COL,
    input  logic [1:0]    MOVE_PLAYER,
    output logic [LW-1:0] VERTICAL,
    output logic [LW-1:0] HORIZONTAL,
    output logic [1:0]    DIAGONAL,
    output logic          ZERO,
    output logic          ALL,
    output logic [1:0]    WIN,
    output logic          DONE,
    output logic          ERR
);
    localparam int KW = $clog2(2*N+2);
    localparam int OW = $clog2(N*N+1);
    localparam logic [KW-1:0] K_LAST = KW'(2*N+1);

    typedef enum logic {IDLE, SCAN} state_t;
    state_t state_reg, state_next;

    logic [1:0]    board_reg [N][N];
    logic [OW-1:0] occ_reg;
    logic [KW-1:0] k_reg;
    logic [LW-1:0] sh_h_reg, sh_v_reg, sh_h_next, sh_v_next;
    logic [1:0]    sh_d_reg, sh_d_next, sh_win_reg, sh_win_next;

    logic [1:0]    line_cell [N];
    logic [N-1:0]  cell_match;
    logic          line_full;
    logic [KW-1:0] k_col;
    logic          wipe, move_fire, move_oob, move_bad, move_legal;

    assign wipe       = RST || CLEAR;
    assign MOVE_READY = (state_reg == IDLE);
    assign k_col      = k_reg - KW'(N);

    // Out-of-range indices are caught before the cell lookup matters.
    assign move_oob   = ({1'b0, MOVE_ROW} >= (CW+1)'(N)) || ({1'b0, MOVE_COL} >= (CW+1)'(N));
    assign move_bad   = move_oob || (MOVE_PLAYER == 2'd0) || (MOVE_PLAYER == 2'd3) ||
                        (WIN != 2'd0) || (!move_oob && board_reg[MOVE_ROW][MOVE_COL] != 2'd0);
    assign move_fire  = (state_reg == IDLE) && MOVE_VALID && !wipe;
    assign move_legal = move_fire && !move_bad;

    // Cell gi of the line currently addressed by k_reg.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_line
            logic [CW-1:0] r_sel, c_sel;
            always_comb begin
                r_sel = CW'(gi);
                c_sel = CW'(gi);
                if (k_reg < KW'(N)) begin
                    r_sel = k_reg[CW-1:0];
                end else if (k_reg < KW'(2*N)) begin
                    c_sel = k_col[CW-1:0];
                end else if (k_reg != KW'(2*N)) begin
                    c_sel = CW'(N-1-gi);
                end
            end
            assign line_cell[gi]  = board_reg[r_sel][c_sel];
            assign cell_match[gi] = (line_cell[gi] == line_cell[0]);
        end
    endgenerate

    assign line_full = (&cell_match) && (line_cell[0] != 2'd0);

    always_comb begin
        sh_h_next   = sh_h_reg + LW'(line_full && (k_reg < KW'(N)));
        sh_v_next   = sh_v_reg + LW'(line_full && (k_reg >= KW'(N)) && (k_reg < KW'(2*N)));
        sh_d_next   = sh_d_reg + 2'(line_full && (k_reg >= KW'(2*N)));
        sh_win_next = line_full ? line_cell[0] : sh_win_reg;
    end

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_row
            for (genvar gj = 0; gj < N; gj++) begin : g_col
                always_ff @(posedge CLK) begin
                    if (wipe) begin
                        board_reg[gi][gj] <= 2'd0;
                    end else if (move_legal && MOVE_ROW == CW'(gi) && MOVE_COL == CW'(gj)) begin
                        board_reg[gi][gj] <= MOVE_PLAYER;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge CLK) begin
        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        if (wipe) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE:    if (move_legal) state_next = SCAN;
                SCAN:    if (k_reg == K_LAST) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (wipe) begin
            occ_reg    <= '0;
            k_reg      <= '0;
            sh_h_reg   <= '0;
            sh_v_reg   <= '0;
            sh_d_reg   <= '0;
            sh_win_reg <= '0;
            VERTICAL   <= '0;
            HORIZONTAL <= '0;
            DIAGONAL   <= '0;
            WIN        <= '0;
            ZERO       <= 1'b1;
            ALL        <= 1'b0;
            DONE       <= 1'b0;
            ERR        <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= move_fire && move_bad;
            if (move_legal) begin
                occ_reg    <= occ_reg + OW'(1);
                k_reg      <= '0;
                sh_h_reg   <= '0;
                sh_v_reg   <= '0;
                sh_d_reg   <= '0;
                sh_win_reg <= '0;
            end
            if (state_reg == SCAN) begin
                k_reg      <= k_reg + KW'(1);
                sh_h_reg   <= sh_h_next;
                sh_v_reg   <= sh_v_next;
                sh_d_reg   <= sh_d_next;
                sh_win_reg <= sh_win_next;
                if (k_reg == K_LAST) begin
                    HORIZONTAL <= sh_h_next;
                    VERTICAL   <= sh_v_next;
                    DIAGONAL   <= sh_d_next;
                    WIN        <= sh_win_next;
                    ZERO       <= (occ_reg == '0);
                    ALL        <= (occ_reg == OW'(N*N));
                    DONE       <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_bingo_board_tracker.sv
// Bench for bingo_board_tracker: a board-level model checked every cycle at N=3,
// plus literal checks at N=3 and N=4.
module tb_bingo_board_tracker;
    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, clear, mv;
    logic [1:0] mr, mc, mp;
    logic       ready, zero, all_f, done, err;
    logic [1:0] vert, horiz, diag, win;

    logic       mv4;
    logic [1:0] mr4, mc4, mp4;
    logic       ready4, zero4, all4, done4, err4;
    logic [2:0] vert4, horiz4;
    logic [1:0] diag4, win4;

    bingo_board_tracker #(.N(3)) dut (
        .CLK(clk), .RST(rst), .CLEAR(clear), .MOVE_VALID(mv), .MOVE_READY(ready),
        .MOVE_ROW(mr), .MOVE_COL(mc), .MOVE_PLAYER(mp),
        .VERTICAL(vert), .HORIZONTAL(horiz), .DIAGONAL(diag),
        .ZERO(zero), .ALL(all_f), .WIN(win), .DONE(done), .ERR(err));

    bingo_board_tracker #(.N(4)) dut4 (
        .CLK(clk), .RST(rst), .CLEAR(1'b0), .MOVE_VALID(mv4), .MOVE_READY(ready4),
        .MOVE_ROW(mr4), .MOVE_COL(mc4), .MOVE_PLAYER(mp4),
        .VERTICAL(vert4), .HORIZONTAL(horiz4), .DIAGONAL(diag4),
        .ZERO(zero4), .ALL(all4), .WIN(win4), .DONE(done4), .ERR(err4));

    int checks = 0;
    int passes = 0;

    // Board-level model of the N=3 instance
    int mb [N][N];
    int m_occ, m_cnt, m_v, m_h, m_d, m_win;
    bit m_ready, m_zero, m_all, m_done, m_err;
    bit chk_en = 1'b0;

    task automatic model_reset();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) mb[r][c] = 0;
        m_occ = 0; m_cnt = 0; m_v = 0; m_h = 0; m_d = 0; m_win = 0;
        m_ready = 1; m_zero = 1; m_all = 0;
    endtask

    task automatic model_eval();
        int own;
        bit ok;
        m_h = 0; m_v = 0; m_d = 0; m_win = 0;
        for (int r = 0; r < N; r++) begin
            own = mb[r][0]; ok = (own != 0);
            for (int c = 0; c < N; c++) if (mb[r][c] != own) ok = 0;
            if (ok) begin m_h++; m_win = own; end
        end
        for (int c = 0; c < N; c++) begin
            own = mb[0][c]; ok = (own != 0);
            for (int r = 0; r < N; r++) if (mb[r][c] != own) ok = 0;
            if (ok) begin m_v++; m_win = own; end
        end
        own = mb[0][0]; ok = (own != 0);
        for (int i = 0; i < N; i++) if (mb[i][i] != own) ok = 0;
        if (ok) begin m_d++; m_win = own; end
        own = mb[0][N-1]; ok = (own != 0);
        for (int i = 0; i < N; i++) if (mb[i][N-1-i] != own) ok = 0;
        if (ok) begin m_d++; m_win = own; end
        m_zero = (m_occ == 0);
        m_all  = (m_occ == N*N);
    endtask

    always @(posedge clk) begin
        m_done = 0;
        m_err  = 0;
        if (rst || clear) begin
            model_reset();
        end else if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
                model_eval();
                m_done  = 1;
                m_ready = 1;
            end
        end else if (mv) begin
            if (mr >= N || mc >= N || mp == 0 || mp == 3 || m_win != 0 || mb[mr][mc] != 0) begin
                m_err = 1;
            end else begin
                mb[mr][mc] = mp;
                m_occ++;
                m_cnt   = 2*N + 2;
                m_ready = 0;
            end
        end
    end

    logic [12:0] act_vec, exp_vec;
    always @(negedge clk) begin
        if (chk_en) begin
            act_vec = {ready, vert, horiz, diag, zero, all_f, win, done, err};
            exp_vec = {m_ready, 2'(m_v), 2'(m_h), 2'(m_d), m_zero, m_all, 2'(m_win), m_done, m_err};
            checks++;
            if (act_vec === exp_vec) passes++;
            else $display("FAIL model t=%0t got rdy/v/h/d/z/a/w/dn/er=%b required %b",
                          $time, act_vec, exp_vec);
        end
    end

    task automatic check_lit(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d required %0d", name, act, exp);
    endtask

    task automatic move(input int r, input int c, input int p);
        @(negedge clk); #2;
        mv = 1; mr = r[1:0]; mc = c[1:0]; mp = p[1:0];
        @(negedge clk); #2;
        mv = 0;
    endtask

    task automatic move4(input int r, input int c, input int p);
        @(negedge clk); #2;
        mv4 = 1; mr4 = r[1:0]; mc4 = c[1:0]; mp4 = p[1:0];
        @(negedge clk); #2;
        mv4 = 0;
    endtask

    // Counts edges after the accepting edge until DONE is seen.
    task automatic wait_done(input bit four, output int cyc);
        bit seen;
        seen = 0;
        cyc  = 0;
        while (!seen && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            seen = four ? done4 : done;
        end
        if (!seen) begin
            checks++;
            $display("FAIL done_timeout: got no DONE within %0d cycles required DONE", cyc);
        end
    endtask

    task automatic do_clear();
        @(negedge clk); #2; clear = 1;
        @(negedge clk); #2; clear = 0;
    endtask

    task automatic play(input int r, input int c, input int p);
        int cyc;
        move(r, c, p);
        wait_done(1'b0, cyc);
    endtask

    initial begin
        int cyc;
        bit saw_done;
        rst = 1; clear = 0; mv = 0; mr = 0; mc = 0; mp = 0;
        mv4 = 0; mr4 = 0; mc4 = 0; mp4 = 0;
        @(posedge clk); #1;
        chk_en = 1;
        @(negedge clk); #2; rst = 0;

        check_lit("reset_ready", ready, 1);
        check_lit("reset_zero", zero, 1);
        check_lit("reset_win", win, 0);
        check_lit("reset_counts", {vert, horiz, diag}, 0);
        check_lit("reset_ready4", ready4, 1);
        check_lit("reset_zero4", zero4, 1);

        move(1, 1, 1);
        wait_done(1'b0, cyc);
        check_lit("first_latency", cyc, 8);
        check_lit("first_zero", zero, 0);
        check_lit("first_counts", {vert, horiz, diag}, 0);

        do_clear();
        play(0, 0, 1); play(1, 0, 2); play(0, 1, 1); play(1, 1, 2); play(0, 2, 1);
        check_lit("row_h", horiz, 1);
        check_lit("row_v", vert, 0);
        check_lit("row_d", diag, 0);
        check_lit("row_win", win, 1);
        move(2, 2, 2);
        check_lit("after_win_err", err, 1);
        @(negedge clk);
        check_lit("after_win_h", horiz, 1);

        do_clear();
        play(0, 0, 1);
        move(0, 0, 2);
        check_lit("occupied_err", err, 1);
        move(1, 1, 3);
        check_lit("player3_err", err, 1);
        move(3, 0, 1);
        check_lit("row3_err", err, 1);
        move(1, 1, 0);
        check_lit("player0_err", err, 1);
        repeat (10) @(negedge clk);
        check_lit("illegal_zero", zero, 0);

        do_clear();
        play(0, 0, 1); play(0, 1, 2); play(0, 2, 1);
        play(1, 0, 1); play(1, 1, 2); play(1, 2, 2);
        play(2, 0, 2); play(2, 1, 1); play(2, 2, 1);
        check_lit("draw_all", all_f, 1);
        check_lit("draw_win", win, 0);
        check_lit("draw_counts", {vert, horiz, diag}, 0);
        move(0, 0, 1);
        check_lit("full_err", err, 1);

        do_clear();
        move(0, 0, 1);
        repeat (3) @(negedge clk);
        #2; clear = 1;
        @(posedge clk); #1; clear = 0;
        check_lit("abort_ready", ready, 1);
        check_lit("abort_zero", zero, 1);
        saw_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check_lit("abort_no_done", saw_done, 0);
        check_lit("abort_counts", {vert, horiz, diag}, 0);

        for (int i = 0; i < 4; i++) begin
            move4(i, i, 1);
            wait_done(1'b1, cyc);
            check_lit("n4_latency", cyc, 10);
        end
        check_lit("n4_diag", diag4, 1);
        check_lit("n4_win", win4, 1);
        check_lit("n4_hv", {vert4, horiz4}, 0);
        check_lit("n4_zero", zero4, 0);

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
